// File: rtl/div_bus_master_if.sv
// Client request/response port plus peripheral bus of the divider job sequencer.
// The master modport is the sequencer side; the slave modport is the client and peripheral side.
interface div_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] d_out;
    logic [31:0] d_in;

    modport master (
        input  req_valid, op_a, op_b, d_in,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
        output cs, rd, wr, addr, d_out
    );

    modport slave (
        output req_valid, op_a, op_b, d_in,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  cs, rd, wr, addr, d_out
    );
endinterface

// File: rtl/div_bus_master.sv
// Runs one divide job on the bus peripheral: write A/B, pulse init, poll done, read result.
// Response 9 cycles after accept when done on first poll; one job at a time, req_ready only in IDLE.
module div_bus_master #(
    parameter int POLL_GAP  = 2,
    parameter int MAX_POLLS = 64
) (
    input  logic            clk,
    input  logic            reset,
    div_bus_master_if.master bus
);

    localparam logic [4:0] ADDR_A    = 5'h04;
    localparam logic [4:0] ADDR_B    = 5'h08;
    localparam logic [4:0] ADDR_INIT = 5'h0C;
    localparam logic [4:0] ADDR_RES  = 5'h10;
    localparam logic [4:0] ADDR_DONE = 5'h14;

    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [7:0]       MAX_P     = 8'(MAX_POLLS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_INIT1,
        S_WR_INIT0,
        S_POLL_RD,
        S_POLL_CHK,
        S_GAP,
        S_RES_RD,
        S_RES_CHK,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [7:0]       poll_q, poll_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             cs_q, cs_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [4:0]       addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;

    // Next state and job bookkeeping.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        poll_d     = poll_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    a_d    = bus.op_a;
                    b_d    = bus.op_b;
                    poll_d = 8'd0;
                    gap_d  = '0;
                    if (bus.op_b == 16'd0) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'd0;
                    end else begin
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A:     state_d = S_WR_B;
            S_WR_B:     state_d = S_WR_INIT1;
            S_WR_INIT1: state_d = S_WR_INIT0;
            S_WR_INIT0: state_d = S_POLL_RD;
            S_POLL_RD: begin
                poll_d  = poll_q + 8'd1;
                state_d = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                // d_in holds the done register read issued in the previous cycle.
                if (bus.d_in[0]) begin
                    state_d = S_RES_RD;
                end else if (poll_q == MAX_P) begin
                    state_d    = S_RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                end else if (POLL_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    state_d = S_POLL_RD;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_RES_RD:   state_d = S_RES_CHK;
            S_RES_CHK: begin
                rsp_data_d = bus.d_in;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every output is a plain flop.
    always_comb begin
        cs_d        = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        addr_d      = 5'h00;
        dout_d      = 16'h0000;
        rsp_valid_d = (state_d == S_RESP);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);

        case (state_d)
            S_WR_A: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_A;
                dout_d = a_d;
            end
            S_WR_B: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_B;
                dout_d = b_d;
            end
            S_WR_INIT1: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_INIT;
                dout_d = 16'h0001;
            end
            S_WR_INIT0: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = ADDR_INIT;
                dout_d = 16'h0000;
            end
            S_POLL_RD: begin
                cs_d   = 1'b1;
                rd_d   = 1'b1;
                addr_d = ADDR_DONE;
            end
            S_RES_RD: begin
                cs_d   = 1'b1;
                rd_d   = 1'b1;
                addr_d = ADDR_RES;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            poll_q      <= 8'd0;
            gap_q       <= '0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 5'h00;
            dout_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
    assign bus.cs        = cs_q;
    assign bus.rd        = rd_q;
    assign bus.wr        = wr_q;
    assign bus.addr      = addr_q;
    assign bus.d_out     = dout_q;

endmodule

// File: tb/tb_div_bus_master.sv
// Bench for div_bus_master: divider peripheral model, bus-trace scoreboard, per-scenario tasks.
module tb_div_bus_master;

    localparam int GAP  = 2;
    localparam int MAXP = 5;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] dat;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rel;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    div_bus_master_if bus();

    div_bus_master #(.POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   poll_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_at = 1;
    int   poll_n = 0;
    logic [15:0] per_a, per_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider peripheral: done reads as 1 from the done_at-th poll after init (never if 0).
    always @(posedge clk) begin
        if (bus.cs && bus.wr) begin
            if (bus.addr == 5'h04) per_a <= bus.d_out;
            if (bus.addr == 5'h08) per_b <= bus.d_out;
            if (bus.addr == 5'h0C && bus.d_out[0]) poll_n <= 0;
        end
        if (bus.cs && bus.rd) begin
            if (bus.addr == 5'h14) begin
                poll_n <= poll_n + 1;
                bus.d_in <= {31'b0, (done_at != 0 && poll_n + 1 >= done_at)};
            end else begin
                bus.d_in <= (per_b != 16'd0) ? {16'h0, per_a / per_b} : 32'hFFFF_FFFF;
            end
        end
    end

    // Bus scoreboard: every access is popped against the expected trace; idle cycles must be all zero.
    always @(negedge clk) begin : mon
        bus_t e;
        if (reset) begin
            if (bus.cs) begin
                n_cmp++;
                if (exp_bus.size() == 0) begin
                    n_bad++;
                    $display("FAIL bus_unexpected: got wr=%b rd=%b addr=%h d_out=%h, required no access",
                             bus.wr, bus.rd, bus.addr, bus.d_out);
                end else begin
                    e = exp_bus.pop_front();
                    if (bus.wr !== e.wr || bus.rd !== !e.wr || bus.addr !== e.addr ||
                        (e.wr && bus.d_out !== e.dat)) begin
                        n_bad++;
                        $display("FAIL bus_access: got wr=%b rd=%b addr=%h d_out=%h, required wr=%b addr=%h d_out=%h",
                                 bus.wr, bus.rd, bus.addr, bus.d_out, e.wr, e.addr, e.dat);
                    end
                end
                if (bus.rd && bus.addr == 5'h14) poll_cyc.push_back(cyc);
            end else begin
                n_cmp++;
                if ({bus.rd, bus.wr, bus.addr, bus.d_out} !== 23'd0) begin
                    n_bad++;
                    $display("FAIL bus_idle: got rd=%b wr=%b addr=%h d_out=%h, required all 0",
                             bus.rd, bus.wr, bus.addr, bus.d_out);
                end
            end
        end
    end

    task automatic push_expect(input logic [15:0] a, input logic [15:0] b, input int npolls, input bit done);
        rsp_t r;
        if (b == 16'd0) begin
            r.data = 32'd0; r.err = 1'b1; r.rel = 1;
        end else begin
            exp_bus.push_back('{1'b1, 5'h04, a});
            exp_bus.push_back('{1'b1, 5'h08, b});
            exp_bus.push_back('{1'b1, 5'h0C, 16'h0001});
            exp_bus.push_back('{1'b1, 5'h0C, 16'h0000});
            for (int i = 0; i < npolls; i++) exp_bus.push_back('{1'b0, 5'h14, 16'h0000});
            if (done) begin
                exp_bus.push_back('{1'b0, 5'h10, 16'h0000});
                r.data = {16'h0, a / b}; r.err = 1'b0; r.rel = 9 + (npolls - 1) * (2 + GAP);
            end else begin
                r.data = 32'd0; r.err = 1'b1; r.rel = 7 + (npolls - 1) * (2 + GAP);
            end
        end
        exp_rsp.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic start_job(input logic [15:0] a, input logic [15:0] b, input bit hold,
                             output int c_acc, output bit ok);
        ok = 1'b0; c_acc = 0;
        bus.req_valid = 1'b1; bus.op_a = a; bus.op_b = b;
        for (int i = 0; i < 100; i++) begin
            if (bus.req_ready === 1'b1) begin ok = 1'b1; c_acc = cyc; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (!hold) begin
            bus.req_valid = 1'b0; bus.op_a = ~a; bus.op_b = 16'h0000;
        end
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int at_cyc,
                            output logic [31:0] d, output logic e);
        got = 1'b0; at_cyc = 0; d = '0; e = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1; at_cyc = cyc; d = bus.rsp_data; e = bus.rsp_err; break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.op_a = 16'h0; bus.op_b = 16'h0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b, required 0000",
                              {bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err});
        end
        n_cmp++;
        if ({bus.cs, bus.rd, bus.wr, bus.addr, bus.d_out} !== 24'd0) begin
            n_bad++; $display("FAIL reset_bus: got %h, required 0", {bus.cs, bus.rd, bus.wr, bus.addr, bus.d_out});
        end
        n_cmp++;
        if (bus.rsp_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: got %h, required 0", bus.rsp_data);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_before_edge: got %b, required 0", bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_release: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_basic();
        int c; bit ok, got; int at; logic [31:0] d; logic e; rsp_t r;
        done_at = 1;
        push_expect(16'h0031, 16'h0007, 1, 1'b1);
        start_job(16'h0031, 16'h0007, 1'b0, c, ok);
        wait_rsp(40, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!ok || !got) begin
            n_bad++; $display("FAIL basic_handshake: got accept=%b rsp=%b, required 1 1", ok, got);
        end else begin
            n_cmp += 3;
            if (at - c !== r.rel) begin n_bad++; $display("FAIL basic_latency: got %0d, required %0d", at - c, r.rel); end
            if (d !== r.data) begin n_bad++; $display("FAIL basic_data: got %h, required %h", d, r.data); end
            if (e !== r.err) begin n_bad++; $display("FAIL basic_err: got %b, required %b", e, r.err); end
        end
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_at_rsp: got %b, required 1", bus.busy); end
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 3'b010) begin
            n_bad++; $display("FAIL basic_after_rsp: got valid/ready/busy=%b, required 010",
                              {bus.rsp_valid, bus.req_ready, bus.busy});
        end
        n_cmp++;
        if (bus.rsp_data !== 32'h7) begin n_bad++; $display("FAIL basic_data_held: got %h, required 00000007", bus.rsp_data); end
        n_cmp++;
        if (exp_bus.size() != 0) begin n_bad++; $display("FAIL basic_trace_left: got %0d pending, required 0", exp_bus.size()); end
        exp_bus.delete();
    endtask

    task automatic test_div0();
        int c; bit ok, got; int at; logic [31:0] d; logic e; rsp_t r;
        push_expect(16'h1234, 16'h0000, 0, 1'b0);
        start_job(16'h1234, 16'h0000, 1'b0, c, ok);
        wait_rsp(10, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!ok || !got) begin
            n_bad++; $display("FAIL div0_handshake: got accept=%b rsp=%b, required 1 1", ok, got);
        end else begin
            n_cmp += 3;
            if (at - c !== r.rel) begin n_bad++; $display("FAIL div0_latency: got %0d, required %0d", at - c, r.rel); end
            if (d !== r.data) begin n_bad++; $display("FAIL div0_data: got %h, required %h", d, r.data); end
            if (e !== r.err) begin n_bad++; $display("FAIL div0_err: got %b, required %b", e, r.err); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_slow();
        int c; bit ok, got; int at; logic [31:0] d; logic e; rsp_t r;
        done_at = 4;
        poll_cyc.delete();
        push_expect(16'd1000, 16'd33, 4, 1'b1);
        start_job(16'd1000, 16'd33, 1'b0, c, ok);
        wait_rsp(60, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!ok || !got) begin
            n_bad++; $display("FAIL slow_handshake: got accept=%b rsp=%b, required 1 1", ok, got);
        end else begin
            n_cmp += 3;
            if (at - c !== r.rel) begin n_bad++; $display("FAIL slow_latency: got %0d, required %0d", at - c, r.rel); end
            if (d !== r.data) begin n_bad++; $display("FAIL slow_data: got %h, required %h", d, r.data); end
            if (e !== r.err) begin n_bad++; $display("FAIL slow_err: got %b, required %b", e, r.err); end
        end
        n_cmp++;
        if (poll_cyc.size() != 4) begin
            n_bad++; $display("FAIL slow_poll_count: got %0d, required 4", poll_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (poll_cyc[i] - poll_cyc[i-1] != 2 + GAP) begin
                    n_bad++; $display("FAIL slow_poll_spacing: got %0d, required %0d", poll_cyc[i] - poll_cyc[i-1], 2 + GAP);
                end
            end
        end
        n_cmp++;
        if (exp_bus.size() != 0) begin n_bad++; $display("FAIL slow_trace_left: got %0d pending, required 0", exp_bus.size()); end
        exp_bus.delete();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int c; bit ok, got; int at; logic [31:0] d; logic e; rsp_t r;
        done_at = 0;
        poll_cyc.delete();
        push_expect(16'h00FF, 16'h0003, MAXP, 1'b0);
        start_job(16'h00FF, 16'h0003, 1'b0, c, ok);
        wait_rsp(80, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!ok || !got) begin
            n_bad++; $display("FAIL timeout_handshake: got accept=%b rsp=%b, required 1 1", ok, got);
        end else begin
            n_cmp += 3;
            if (at - c !== r.rel) begin n_bad++; $display("FAIL timeout_latency: got %0d, required %0d", at - c, r.rel); end
            if (d !== r.data) begin n_bad++; $display("FAIL timeout_data: got %h, required %h", d, r.data); end
            if (e !== r.err) begin n_bad++; $display("FAIL timeout_err: got %b, required %b", e, r.err); end
        end
        n_cmp++;
        if (poll_cyc.size() != MAXP) begin n_bad++; $display("FAIL timeout_polls: got %0d, required %0d", poll_cyc.size(), MAXP); end
        n_cmp++;
        if (exp_bus.size() != 0) begin n_bad++; $display("FAIL timeout_trace_left: got %0d pending, required 0", exp_bus.size()); end
        exp_bus.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c; bit ok, got, found, stray; int at; logic [31:0] d; logic e; rsp_t r;
        done_at = 1;
        found = 1'b0; stray = 1'b0;
        push_expect(16'h0031, 16'h0007, 1, 1'b1);
        start_job(16'h0031, 16'h0007, 1'b0, c, ok);
        for (int i = 0; i < 20; i++) begin
            #2;
            if (bus.cs && bus.rd && bus.addr == 5'h14) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL midreset_poll_seen: got 0, required 1"); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.cs, bus.rd} !== 2'b00) begin n_bad++; $display("FAIL midreset_async: got cs/rd=%b, required 00", {bus.cs, bus.rd}); end
        n_cmp++;
        if (exp_bus.size() != 1) begin n_bad++; $display("FAIL midreset_trace: got %0d pending, required 1", exp_bus.size()); end
        exp_bus.delete();
        exp_rsp.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) stray = 1'b1;
        end
        n_cmp++;
        if (stray) begin n_bad++; $display("FAIL midreset_no_rsp: got rsp_valid=1, required 0"); end
        push_expect(16'd49, 16'd7, 1, 1'b1);
        start_job(16'd49, 16'd7, 1'b0, c, ok);
        wait_rsp(40, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!ok || !got) begin
            n_bad++; $display("FAIL midreset_handshake: got accept=%b rsp=%b, required 1 1", ok, got);
        end else begin
            n_cmp += 2;
            if (at - c !== r.rel) begin n_bad++; $display("FAIL midreset_latency: got %0d, required %0d", at - c, r.rel); end
            if ({e, d} !== {r.err, r.data}) begin n_bad++; $display("FAIL midreset_result: got %b/%h, required %b/%h", e, d, r.err, r.data); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c1, c2; bit ok, got; int at; logic [31:0] d; logic e; rsp_t r;
        done_at = 1;
        push_expect(16'h0031, 16'h0007, 1, 1'b1);
        push_expect(16'h0064, 16'h000A, 1, 1'b1);
        start_job(16'h0031, 16'h0007, 1'b1, c1, ok);
        bus.op_a = 16'h0064; bus.op_b = 16'h000A;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_first_accept: got 0, required 1"); end
        r = exp_rsp.pop_front();
        for (int k = 1; k <= 9; k++) begin
            n_cmp++;
            if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_job: got 1 in cycle %0d, required 0", k); end
            if (k == 9) begin
                n_cmp++;
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, r.err, r.data}) begin
                    n_bad++; $display("FAIL b2b_first_rsp: got v=%b e=%b d=%h, required v=1 e=%b d=%h",
                                      bus.rsp_valid, bus.rsp_err, bus.rsp_data, r.err, r.data);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got ready=%b, required 1", bus.req_ready); end
        c2 = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(40, got, at, d, e);
        r = exp_rsp.pop_front();
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL b2b_second_rsp: got none, required response");
        end else begin
            n_cmp += 2;
            if (at - c2 !== r.rel) begin n_bad++; $display("FAIL b2b_second_latency: got %0d, required %0d", at - c2, r.rel); end
            if ({e, d} !== {r.err, r.data}) begin n_bad++; $display("FAIL b2b_second_result: got %b/%h, required %b/%h", e, d, r.err, r.data); end
        end
        n_cmp++;
        if (exp_bus.size() != 0) begin n_bad++; $display("FAIL b2b_trace_left: got %0d pending, required 0", exp_bus.size()); end
        exp_bus.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_div0();
        test_slow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
